// File: rtl/axis_xbar_pkg.sv
// Shared types and helpers for the AXI-Stream crossbar blocks.
// Arbitration modes, arbiter states and pointer arithmetic.
package axis_xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int rr_next(
    input int ptr,
    input int n
  );
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with registered outputs and registered
// input ready; sustains one beat per cycle under constant ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push;

  assign s_ready = ~skid_valid_q;
  assign push    = s_valid & s_ready;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || m_ready) begin
      // skid only fills while the output is stalled, so no push here
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = s_data;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter_mx1.sv
// Packet-aware M:1 AXI-Stream arbiter, round-robin or fixed priority,
// with a registered skid-buffered output tagged by source channel.
module axis_rr_packet_arbiter_mx1
  import axis_xbar_pkg::*;
#(
  parameter int  CHANNEL_NO = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  ARB_MODE   = ARB_RR,
  localparam int SEL_WIDTH  = (CHANNEL_NO > 1) ? $clog2(CHANNEL_NO) : 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata [CHANNEL_NO],
  input  logic [CHANNEL_NO-1:0] s_axis_tvalid,
  input  logic [CHANNEL_NO-1:0] s_axis_tlast,
  output logic [CHANNEL_NO-1:0] s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [SEL_WIDTH-1:0]  m_axis_tid,
  input  logic                  m_axis_tready,
  output logic                  grant_active
);

  localparam int PW = DATA_WIDTH + 1 + SEL_WIDTH;

  arb_state_t           state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0] winner, search_base;
  logic                 sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                 push_valid, buf_ready;
  logic [PW-1:0]        push_data, pop_data;

  // First requester at or after ptr, wrapping at CHANNEL_NO.
  function automatic logic [SEL_WIDTH-1:0] pick(
    input logic [CHANNEL_NO-1:0] req,
    input logic [SEL_WIDTH-1:0]  ptr
  );
    logic [2*CHANNEL_NO-1:0] dbl;
    logic [CHANNEL_NO-1:0]   rot;
    int                      idx;
    pick = '0;
    dbl  = {req, req};
    rot  = CHANNEL_NO'(dbl >> ptr);
    for (int i = CHANNEL_NO - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = int'(ptr) + i;
        if (idx >= CHANNEL_NO) begin
          idx = idx - CHANNEL_NO;
        end
        pick = SEL_WIDTH'(idx);
      end
    end
  endfunction

  assign search_base = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_q;
  assign winner      = pick(s_axis_tvalid, search_base);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    if (int'(grant_q) < CHANNEL_NO) begin
      sel_valid = s_axis_tvalid[grant_q];
      sel_last  = s_axis_tlast[grant_q];
      sel_data  = s_axis_tdata[grant_q];
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    s_axis_tready = '0;
    push_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_d = winner;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        s_axis_tready[grant_q] = buf_ready;
        push_valid = sel_valid;
        if (sel_valid && buf_ready && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = SEL_WIDTH'(rr_next(int'(grant_q), CHANNEL_NO));
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign push_data    = {grant_q, sel_last, sel_data};
  assign grant_active = (state_q == ACTIVE);

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .aclk   (aclk),
    .areset (areset),
    .s_data (push_data),
    .s_valid(push_valid),
    .s_ready(buf_ready),
    .m_data (pop_data),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign m_axis_tid   = pop_data[PW-1 -: SEL_WIDTH];
  assign m_axis_tlast = pop_data[DATA_WIDTH];
  assign m_axis_tdata = pop_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_rr_packet_arbiter_mx1.sv
// Bench for the packet arbiter: queue-driven sources, packet-level
// reference model, three configurations (4ch RR, 3ch RR, 4ch fixed).
module tb_axis_rr_packet_arbiter_mx1;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int sel = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [3:0]  tv = '0;
  logic [3:0]  tl = '0;
  logic [31:0] td [4];
  logic        mrdy = 1'b0;

  logic [3:0]  tv_a, rdy_a;
  logic [31:0] md_a;
  logic        mv_a, ml_a, ga_a;
  logic [1:0]  mid_a;

  logic [2:0]  tv_b, rdy_b;
  logic [31:0] td3 [3];
  logic [31:0] md_b;
  logic        mv_b, ml_b, ga_b;
  logic [1:0]  mid_b;

  logic [3:0]  tv_c, rdy_c;
  logic [31:0] md_c;
  logic        mv_c, ml_c, ga_c;
  logic [1:0]  mid_c;

  assign tv_a   = (sel == 0) ? tv : 4'b0;
  assign tv_b   = (sel == 1) ? tv[2:0] : 3'b0;
  assign tv_c   = (sel == 2) ? tv : 4'b0;
  assign td3[0] = td[0];
  assign td3[1] = td[1];
  assign td3[2] = td[2];

  axis_rr_packet_arbiter_mx1 #(
    .CHANNEL_NO(4), .DATA_WIDTH(32), .ARB_MODE(0)
  ) dut_a (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(td), .s_axis_tvalid(tv_a),
    .s_axis_tlast(tl), .s_axis_tready(rdy_a),
    .m_axis_tdata(md_a), .m_axis_tvalid(mv_a),
    .m_axis_tlast(ml_a), .m_axis_tid(mid_a),
    .m_axis_tready(mrdy), .grant_active(ga_a)
  );

  axis_rr_packet_arbiter_mx1 #(
    .CHANNEL_NO(3), .DATA_WIDTH(32), .ARB_MODE(0)
  ) dut_b (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(td3), .s_axis_tvalid(tv_b),
    .s_axis_tlast(tl[2:0]), .s_axis_tready(rdy_b),
    .m_axis_tdata(md_b), .m_axis_tvalid(mv_b),
    .m_axis_tlast(ml_b), .m_axis_tid(mid_b),
    .m_axis_tready(mrdy), .grant_active(ga_b)
  );

  axis_rr_packet_arbiter_mx1 #(
    .CHANNEL_NO(4), .DATA_WIDTH(32), .ARB_MODE(1)
  ) dut_c (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(td), .s_axis_tvalid(tv_c),
    .s_axis_tlast(tl), .s_axis_tready(rdy_c),
    .m_axis_tdata(md_c), .m_axis_tvalid(mv_c),
    .m_axis_tlast(ml_c), .m_axis_tid(mid_c),
    .m_axis_tready(mrdy), .grant_active(ga_c)
  );

  logic [3:0]  rdy;
  logic        mv, ml, ga;
  logic [1:0]  mid;
  logic [31:0] md;
  always_comb begin
    rdy = rdy_a; mv = mv_a; ml = ml_a;
    ga = ga_a; mid = mid_a; md = md_a;
    if (sel == 1) begin
      rdy = {1'b0, rdy_b}; mv = mv_b; ml = ml_b;
      ga = ga_b; mid = mid_b; md = md_b;
    end else if (sel == 2) begin
      rdy = rdy_c; mv = mv_c; ml = ml_c;
      ga = ga_c; mid = mid_c; md = md_c;
    end
  end

  // source queues: {last, data}; observed/expected beats: {tid, last, data}
  logic [32:0] q [4][$];
  logic [34:0] obs [$];
  logic [34:0] expq [$];
  int          obs_cyc [$];
  bit          in_pkt [4];
  bit          hs [4];
  bit          stall_prev;
  logic [34:0] stall_pay;
  int          m_ptr;
  int          gap_pct;
  int          rdy_mode;
  int          rdy_idx;
  logic [3:0]  rdy_pat = 4'b1001;

  task automatic step();
    @(posedge aclk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (hs[c] && q[c].size() > 0) begin
        in_pkt[c] = !q[c][0][32];
        void'(q[c].pop_front());
      end
      if (!tv[c] || hs[c]) begin
        if (q[c].size() > 0 &&
            !(in_pkt[c] && $urandom_range(99) < gap_pct)) begin
          tv[c] = 1'b1;
          td[c] = q[c][0][31:0];
          tl[c] = q[c][0][32];
        end else begin
          tv[c] = 1'b0;
        end
      end
    end
    case (rdy_mode)
      0: mrdy = 1'b1;
      1: mrdy = rdy_pat[rdy_idx % 4];
      default: mrdy = ($urandom_range(99) < 60);
    endcase
    rdy_idx++;
    @(negedge aclk);
    for (int c = 0; c < 4; c++) hs[c] = tv[c] & rdy[c];
    checks++;
    if ($countones(rdy) > 1 || (!ga && rdy != 4'b0)) begin
      errors++;
      $display("FAIL tready_onehot: got %b ga=%b", rdy, ga);
    end
    if (stall_prev) begin
      checks++;
      if (!mv || {mid, ml, md} !== stall_pay) begin
        errors++;
        $display("FAIL stall_stable: got v=%b %h expected v=1 %h",
                 mv, {mid, ml, md}, stall_pay);
      end
    end
    if (mv && mrdy) begin
      obs.push_back({mid, ml, md});
      obs_cyc.push_back(cyc);
    end
    stall_prev = mv & ~mrdy;
    stall_pay  = {mid, ml, md};
  endtask

  task automatic clear_tb();
    for (int c = 0; c < 4; c++) begin
      q[c].delete();
      in_pkt[c] = 1'b0;
      hs[c] = 1'b0;
    end
    tv = '0;
    obs.delete(); obs_cyc.delete(); expq.delete();
    m_ptr = 0;
    stall_prev = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    rdy_mode = 0; gap_pct = 0; rdy_idx = 0;
    clear_tb();
    step();
    step();
    areset = 1'b0;
    obs.delete(); obs_cyc.delete();
  endtask

  task automatic add_pkt(input int ch, input int len,
                         input logic [31:0] base, input bit rnd);
    for (int i = 0; i < len; i++)
      q[ch].push_back({(i == len - 1), rnd ? 32'($urandom) : base + 32'(i)});
  endtask

  // Packet-level model: whole packets in arbitration order.
  task automatic build_exp(input bit fixed, input int n);
    logic [32:0] m [4][$];
    logic [32:0] b;
    int ch;
    for (int c = 0; c < 4; c++) m[c] = q[c];
    forever begin
      ch = -1;
      for (int i = 0; i < n; i++) begin
        int cc;
        cc = fixed ? i : (m_ptr + i) % n;
        if (ch < 0 && m[cc].size() > 0) ch = cc;
      end
      if (ch < 0) break;
      do begin
        b = m[ch].pop_front();
        expq.push_back({2'(ch), b});
      end while (!b[32]);
      m_ptr = (ch + 1) % n;
    end
  endtask

  function automatic bit busy();
    bit r;
    r = (obs.size() < expq.size());
    for (int c = 0; c < 4; c++) if (q[c].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic run_check(input string name, input bit timed);
    int start, n, gap;
    step();
    start = cyc;
    n = 0;
    while (busy() && n < 3000) begin
      step();
      n++;
    end
    repeat (8) step();
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d beats expected %0d",
               name, obs.size(), expq.size());
    end
    checks++;
    if (obs.size() != expq.size()) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d",
               name, obs.size(), expq.size());
    end
    for (int k = 0; k < obs.size() && k < expq.size(); k++) begin
      checks++;
      if (obs[k] !== expq[k]) begin
        errors++;
        $display("FAIL %s beat %0d: got %h expected %h",
                 name, k, obs[k], expq[k]);
      end
    end
    if (timed && obs.size() > 0 && obs.size() == expq.size()) begin
      checks++;
      if (obs_cyc[0] - start != 2) begin
        errors++;
        $display("FAIL %s latency: got %0d expected 2",
                 name, obs_cyc[0] - start);
      end
      for (int k = 1; k < obs.size(); k++) begin
        gap = expq[k-1][32] ? 2 : 1;
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != gap) begin
          errors++;
          $display("FAIL %s spacing %0d: got %0d expected %0d",
                   name, k, obs_cyc[k] - obs_cyc[k-1], gap);
        end
      end
    end
    obs.delete(); obs_cyc.delete(); expq.delete();
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    checks++;
    if ({rdy, mv, ml, mid, md, ga} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b v=%b l=%b id=%0d d=%h ga=%b expected all 0",
               rdy, mv, ml, mid, md, ga);
    end
  endtask

  task automatic test_rr_fairness();
    sel = 0;
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 4; c++) add_pkt(c, 3, 0, 1'b1);
    build_exp(1'b0, 4);
    run_check("rr_fair", 1'b1);
  endtask

  task automatic test_nonpow2_wrap();
    sel = 1;
    do_reset();
    add_pkt(1, 2, 32'h100, 1'b0);
    build_exp(1'b0, 3);
    run_check("np_warm", 1'b1);
    add_pkt(0, 3, 32'h200, 1'b0);
    add_pkt(2, 3, 32'h300, 1'b0);
    build_exp(1'b0, 3);
    run_check("np_wrap", 1'b1);
  endtask

  task automatic test_fixed_priority();
    sel = 2;
    do_reset();
    gap_pct = 30;
    rdy_mode = 2;
    for (int p = 0; p < 3; p++) add_pkt(1, $urandom_range(4, 2), 0, 1'b1);
    for (int p = 0; p < 2; p++) add_pkt(3, $urandom_range(4, 2), 0, 1'b1);
    build_exp(1'b1, 4);
    run_check("fixed", 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    do_reset();
    rdy_mode = 1;
    add_pkt(0, 8, 32'h10, 1'b0);
    build_exp(1'b0, 4);
    run_check("backpressure", 1'b0);
  endtask

  task automatic test_single_beat();
    sel = 0;
    do_reset();
    for (int c = 0; c < 4; c++) add_pkt(c, 1, 0, 1'b1);
    build_exp(1'b0, 4);
    run_check("single_beat", 1'b1);
  endtask

  task automatic test_reset_mid();
    int cnt, n;
    sel = 0;
    do_reset();
    add_pkt(1, 2, 32'h50, 1'b0);
    build_exp(1'b0, 4);
    run_check("rm_warm", 1'b1);
    add_pkt(1, 5, 32'hA0, 1'b0);
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 100) begin
      step();
      if (hs[1]) cnt++;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL rm_start timeout: got %0d beats expected 2", cnt);
    end
    step();
    areset = 1'b1;
    clear_tb();
    step();
    areset = 1'b0;
    checks++;
    if (rdy !== 4'b0 || mv !== 1'b0 || ga !== 1'b0) begin
      errors++;
      $display("FAIL rm_flush: got rdy=%b v=%b ga=%b expected 0 0 0",
               rdy, mv, ga);
    end
    obs.delete(); obs_cyc.delete();
    add_pkt(2, 3, 32'hC0, 1'b0);
    add_pkt(0, 3, 32'hB0, 1'b0);
    build_exp(1'b0, 4);
    run_check("rm_after", 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 4; r++) begin
        sel = s;
        do_reset();
        gap_pct = 25;
        rdy_mode = 2;
        n = (s == 1) ? 3 : 4;
        for (int c = 0; c < n; c++)
          repeat ($urandom_range(3)) add_pkt(c, $urandom_range(6, 1), 0, 1'b1);
        build_exp(s == 2, n);
        run_check("random", 1'b0);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) td[c] = '0;
    test_reset();
    test_rr_fairness();
    test_nonpow2_wrap();
    test_fixed_priority();
    test_backpressure();
    test_single_beat();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
